lock_msg_display: RTL

//  Parametrised, registered successor to the lock's combinational status display.

---
 rtl/lock_disp_pkg.sv | 33 +++
 rtl/seg_char_rom.sv | 40 ++++
 rtl/lock_msg_display.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lock_disp_pkg.sv
// Shared types and constants for the lock status display.
// Character codes, active-low gfedcba patterns and display states.
package lock_disp_pkg;

   typedef enum logic [4:0] {
      C_BLANK, C_O, C_P, C_E, C_N, C_D, C_I, C_T, C_R, C_Y, C_S,
      C_EQ, C_DASH, C_0, C_1, C_2, C_3, C_4, C_5, C_6, C_7, C_8, C_9
   } char_t;

   typedef enum logic [1:0] {
      S_TRIES, S_OPEN, S_DENY_BLINK, S_DENY_HOLD
   } state_t;

   localparam logic [6:0] SEG_O     = 7'h40;
   localparam logic [6:0] SEG_P     = 7'h0C;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_N     = 7'h48;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_I     = 7'h79;
   localparam logic [6:0] SEG_T     = 7'h07;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_Y     = 7'h11;
   localparam logic [6:0] SEG_S     = 7'h12;
   localparam logic [6:0] SEG_EQ    = 7'h37;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

endpackage

// File: rtl/seg_char_rom.sv
// Character-to-segment lookup for one digit.
// Output is active-low, bit order gfedcba.
module seg_char_rom
   import lock_disp_pkg::*;
(
   input  char_t      i_chr,
   output logic [6:0] o_seg
);

   // translate one character code into its pattern
   always_comb begin
      o_seg = SEG_BLANK;
      unique case (i_chr)
         C_O:     o_seg = SEG_O;
         C_P:     o_seg = SEG_P;
         C_E:     o_seg = SEG_E;
         C_N:     o_seg = SEG_N;
         C_D:     o_seg = SEG_D;
         C_I:     o_seg = SEG_I;
         C_T:     o_seg = SEG_T;
         C_R:     o_seg = SEG_R;
         C_Y:     o_seg = SEG_Y;
         C_S:     o_seg = SEG_S;
         C_EQ:    o_seg = SEG_EQ;
         C_DASH:  o_seg = SEG_DASH;
         C_0:     o_seg = SEG_DIGIT[0];
         C_1:     o_seg = SEG_DIGIT[1];
         C_2:     o_seg = SEG_DIGIT[2];
         C_3:     o_seg = SEG_DIGIT[3];
         C_4:     o_seg = SEG_DIGIT[4];
         C_5:     o_seg = SEG_DIGIT[5];
         C_6:     o_seg = SEG_DIGIT[6];
         C_7:     o_seg = SEG_DIGIT[7];
         C_8:     o_seg = SEG_DIGIT[8];
         C_9:     o_seg = SEG_DIGIT[9];
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/lock_msg_display.sv
// Registered lock status display: OPEN / DENIED / TRYS=n.
// Blinks DENIED on failure and scrolls messages wider than the display.
module lock_msg_display
   import lock_disp_pkg::*;
#(
   parameter int NUM_DIGITS  = 6,
   parameter int AW          = 2,
   parameter int SCROLL_DIV  = 25000000,
   parameter int BLINK_DIV   = 12500000,
   parameter int FAIL_BLINKS = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    done,
   input  logic                    fail,
   input  logic [AW-1:0]           attempt,
   output logic [NUM_DIGITS*7-1:0] seg,
   output logic                    busy
);

   localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int HN = 2 * FAIL_BLINKS;
   localparam int HW = (HN > 1) ? $clog2(HN) : 1;

   state_t                  r_state, w_nstate;
   logic [AW-1:0]           r_att;
   logic [2:0]              r_off, w_off_n;
   logic [SW-1:0]           r_sc, w_sc_n;
   logic [BW-1:0]           r_bc, w_bc_n;
   logic [HW-1:0]           r_hc, w_hc_n;
   logic                    r_on, w_on_n;
   logic [NUM_DIGITS*7-1:0] r_seg, w_seg_n;
   logic                    r_busy, w_busy_n;

   char_t      w_msg [8];
   logic [2:0] w_len;
   char_t      w_attc;
   logic [4:0] w_code;
   logic       w_scroll, w_dark, w_chg, w_blink_end;

   assign w_code   = 5'(C_0) + 5'(r_att);
   assign w_attc   = (32'(r_att) > 32'd9) ? C_DASH : char_t'(w_code);
   assign w_scroll = ({29'd0, w_len} > 32'(NUM_DIGITS));
   assign w_dark   = (r_state == S_DENY_BLINK) && !r_on;
   assign w_busy_n = (r_state == S_DENY_BLINK) || w_scroll;
   assign w_blink_end = (r_bc == BW'(BLINK_DIV - 1)) &&
                        (r_hc == HW'(HN - 1));

   // build the character string for the current state
   always_comb begin
      w_msg = '{default: C_BLANK};
      w_len = 3'd6;
      unique case (r_state)
         S_OPEN: begin
            w_msg[0] = C_O; w_msg[1] = C_P;
            w_msg[2] = C_E; w_msg[3] = C_N;
            w_len    = 3'd4;
         end
         S_DENY_BLINK, S_DENY_HOLD: begin
            w_msg[0] = C_D; w_msg[1] = C_E; w_msg[2] = C_N;
            w_msg[3] = C_I; w_msg[4] = C_E; w_msg[5] = C_D;
         end
         default: begin
            w_msg[0] = C_T; w_msg[1] = C_R; w_msg[2] = C_Y;
            w_msg[3] = C_S; w_msg[4] = C_EQ; w_msg[5] = w_attc;
         end
      endcase
   end

   // next state: done dominates, fail only arms from idle states
   always_comb begin
      w_nstate = S_TRIES;
      if (done) begin
         w_nstate = S_OPEN;
      end else if (fail) begin
         unique case (r_state)
            S_TRIES, S_OPEN: w_nstate = S_DENY_BLINK;
            S_DENY_BLINK:    w_nstate = w_blink_end ? S_DENY_HOLD
                                                    : S_DENY_BLINK;
            default:         w_nstate = S_DENY_HOLD;
         endcase
      end
      w_chg = (w_nstate != r_state) ||
              ((r_state == S_TRIES) && (w_nstate == S_TRIES) &&
               (attempt != r_att));
   end

   // scroll and blink dividers restart whenever the message changes
   always_comb begin
      w_off_n = r_off;
      w_sc_n  = r_sc;
      w_bc_n  = r_bc;
      w_hc_n  = r_hc;
      w_on_n  = r_on;
      if (w_chg) begin
         w_off_n = '0;
         w_sc_n  = '0;
         w_bc_n  = '0;
         w_hc_n  = '0;
         w_on_n  = 1'b1;
      end else begin
         if (w_scroll) begin
            if (r_sc == SW'(SCROLL_DIV - 1)) begin
               w_sc_n  = '0;
               w_off_n = (r_off == w_len) ? 3'd0 : r_off + 3'd1;
            end else begin
               w_sc_n = r_sc + 1'b1;
            end
         end
         if (r_state == S_DENY_BLINK) begin
            if (r_bc == BW'(BLINK_DIV - 1)) begin
               w_bc_n = '0;
               w_hc_n = r_hc + 1'b1;
               w_on_n = ~r_on;
            end else begin
               w_bc_n = r_bc + 1'b1;
            end
         end
      end
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      localparam int J = NUM_DIGITS - 1 - gi;
      logic [3:0] w_pos;
      char_t      w_chr;
      logic [6:0] w_pat;

      // pick the character landing on this digit
      always_comb begin
         w_pos = '0;
         w_chr = C_BLANK;
         if (w_scroll) begin
            w_pos = {1'b0, r_off} + 4'(J);
            if (w_pos > {1'b0, w_len})
               w_pos = w_pos - {1'b0, w_len} - 4'd1;
            if (w_pos < {1'b0, w_len})
               w_chr = w_msg[w_pos[2:0]];
         end else if (J < 6) begin
            if (3'(J) < w_len)
               w_chr = w_msg[3'(J)];
         end
      end

      seg_char_rom u_rom (
         .i_chr (w_chr),
         .o_seg (w_pat)
      );

      assign w_seg_n[7*gi +: 7] = w_dark ? SEG_BLANK : w_pat;
   end

   // state, dividers and output registers
   always_ff @(posedge clk) begin
      r_att <= attempt;
      if (!rst_n) begin
         r_state <= S_TRIES;
         r_off   <= '0;
         r_sc    <= '0;
         r_bc    <= '0;
         r_hc    <= '0;
         r_on    <= 1'b1;
         r_seg   <= '1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_off   <= w_off_n;
         r_sc    <= w_sc_n;
         r_bc    <= w_bc_n;
         r_hc    <= w_hc_n;
         r_on    <= w_on_n;
         r_seg   <= w_seg_n;
         r_busy  <= w_busy_n;
      end
   end

   assign seg  = r_seg;
   assign busy = r_busy;

endmodule
